// File: rtl/led_bank_display_if.sv
// ---------------------------------------------------------------------------
// led_bank_display_if
// Row-write port of the LED-array renderer.
//   wr_valid  master -> slave  row-write request
//   wr_ready  slave  -> master write accepted when high with wr_valid
//   wr_row    master -> slave  target row (rows >= ROWS are accepted and dropped)
//   wr_data   master -> slave  row word, MSB is the leftmost LED
// ---------------------------------------------------------------------------
interface led_bank_display_if #(
  parameter int BITS = 8
);
  logic            wr_valid;
  logic            wr_ready;
  logic [2:0]      wr_row;
  logic [BITS-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_row,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_row,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/led_bank_display.sv
// ---------------------------------------------------------------------------
// led_bank_display
// Draws ROWS rows of BITS square LEDs, one row word per row, MSB leftmost.
// Follows the VGA timing generator's pixel coordinates and strobe and emits
// a 3-bit colour two strobes later (stage 1: geometry/bit lookup, stage 2:
// colour select).
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   px_en        pixel strobe; every pixel-path register advances only on it
//   x_px, y_px   current pixel column / line
//   activevideo  visible region
//   wr           row-write port (led_bank_display_if.slave)
//   frame_irq    one-clk pulse after a commit that carried new data
//   color_px     pixel colour
//
// Build option LED_SHADOW_EN:
//   defined   - writes land in a pending buffer, copied to the display
//               buffer at x_px==0, y_px==V_ACTIVE; frame_irq reports it and
//               wr_ready drops for that one cycle.
//   undefined - writes go straight to the display buffer (tearing allowed),
//               wr_ready is always 1 and frame_irq is always 0.
// ---------------------------------------------------------------------------
module led_bank_display #(
  parameter int         BITS     = 8,
  parameter int         ROWS     = 4,
  parameter int         LED_W    = 80,
  parameter int         LED_H    = 80,
  parameter int         BORDER   = 8,
  parameter int         X0       = 0,
  parameter int         Y0       = 0,
  parameter int         V_ACTIVE = 480,
  parameter logic [2:0] C_ON     = 3'b010,
  parameter logic [2:0] C_OFF    = 3'b001,
  parameter logic [2:0] C_BORDER = 3'b111,
  parameter logic [2:0] C_BG     = 3'b000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                px_en,
  input  logic [9:0]          x_px,
  input  logic [9:0]          y_px,
  input  logic                activevideo,
  led_bank_display_if.slave   wr,
  output logic                frame_irq,
  output logic [2:0]          color_px
);

  localparam int CXW  = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam int CYW  = (LED_H > 1) ? $clog2(LED_H) : 1;
  localparam int COLW = $clog2(BITS + 1);
  localparam int ROWW = $clog2(ROWS + 1);
  localparam int BIW  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  // -------------------------------------------------------------------------
  // Geometry counters. The *_cur values are what the counters hold for the
  // pixel being presented right now, so stage 1 sees geometry aligned to
  // x_px/y_px instead of one strobe behind.
  // -------------------------------------------------------------------------
  logic [CXW-1:0]  cx_reg,  cx_cur;
  logic [COLW-1:0] col_reg, col_cur;
  logic [CYW-1:0]  cy_reg,  cy_cur;
  logic [ROWW-1:0] row_reg, row_cur;

  always_comb begin
    cx_cur  = cx_reg;
    col_cur = col_reg;
    if (px_en) begin
      if (x_px == 10'(X0)) begin
        cx_cur  = '0;
        col_cur = '0;
      end else if (cx_reg == CXW'(LED_W - 1)) begin
        cx_cur = '0;
        // saturate so the beam never wraps back into the array
        if (col_reg != COLW'(BITS))
          col_cur = col_reg + COLW'(1);
      end else begin
        cx_cur = cx_reg + CXW'(1);
      end
    end
  end

  // vertical scheme steps once per line, on the strobe with x_px==0
  always_comb begin
    cy_cur  = cy_reg;
    row_cur = row_reg;
    if (px_en && (x_px == 10'd0)) begin
      if (y_px == 10'(Y0)) begin
        cy_cur  = '0;
        row_cur = '0;
      end else if (cy_reg == CYW'(LED_H - 1)) begin
        cy_cur = '0;
        if (row_reg != ROWW'(ROWS))
          row_cur = row_reg + ROWW'(1);
      end else begin
        cy_cur = cy_reg + CYW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cx_reg  <= '0;
      col_reg <= '0;
      cy_reg  <= '0;
      row_reg <= '0;
    end else begin
      cx_reg  <= cx_cur;
      col_reg <= col_cur;
      cy_reg  <= cy_cur;
      row_reg <= row_cur;
    end
  end

  // -------------------------------------------------------------------------
  // Row storage
  // -------------------------------------------------------------------------
  logic           wr_fire;
  logic           row_hit;
  logic [RIW-1:0] wr_idx;
  logic           commit;

  assign wr_fire = wr.wr_valid && wr.wr_ready;
  // widened compare so ROWS==8 does not overflow a 3-bit constant
  assign row_hit = ({1'b0, wr.wr_row} < 4'(ROWS));
  assign wr_idx  = wr.wr_row[RIW-1:0];

  logic [ROWS-1:0][BITS-1:0] disp_all;

`ifdef LED_SHADOW_EN
  logic dirty_reg;
  logic frame_irq_reg;

  assign commit      = px_en && (x_px == 10'd0) && (y_px == 10'(V_ACTIVE));
  // the commit cycle owns the buffers, so a write then must be retried
  assign wr.wr_ready = !commit;
  assign frame_irq   = frame_irq_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dirty_reg     <= 1'b0;
      frame_irq_reg <= 1'b0;
    end else begin
      frame_irq_reg <= commit && dirty_reg;
      if (commit)
        dirty_reg <= 1'b0;
      else if (wr_fire && row_hit)
        dirty_reg <= 1'b1;
    end
  end
`else
  assign commit      = 1'b0;
  assign wr.wr_ready = 1'b1;
  assign frame_irq   = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic            wr_sel;
      logic [BITS-1:0] disp_reg;

      assign wr_sel       = wr_fire && row_hit && (wr_idx == RIW'(gi));
      assign disp_all[gi] = disp_reg;

`ifdef LED_SHADOW_EN
      logic [BITS-1:0] pend_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          pend_reg <= '0;
          disp_reg <= '0;
        end else begin
          if (wr_sel)
            pend_reg <= wr.wr_data;
          if (commit)
            disp_reg <= pend_reg;
        end
      end
`else
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          disp_reg <= '0;
        else if (wr_sel)
          disp_reg <= wr.wr_data;
      end
`endif
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Stage 1: in-array / border flags and the LED bit under the beam
  // -------------------------------------------------------------------------
  logic            in_array_cur;
  logic            border_cur;
  logic [RIW-1:0]  row_idx;
  logic [BIW-1:0]  col_idx;
  logic [BITS-1:0] row_word;
  logic [BITS-1:0] word_rev;
  logic            bit_cur;

  assign in_array_cur = (col_cur < COLW'(BITS)) && (row_cur < ROWW'(ROWS));
  assign border_cur   = (cx_cur < CXW'(BORDER)) || (cx_cur >= CXW'(LED_W - BORDER)) ||
                        (cy_cur < CYW'(BORDER)) || (cy_cur >= CYW'(LED_H - BORDER));

  // clamp indices so out-of-array positions never address past the storage
  assign row_idx  = (row_cur < ROWW'(ROWS)) ? row_cur[RIW-1:0] : '0;
  assign col_idx  = (col_cur < COLW'(BITS)) ? col_cur[BIW-1:0] : '0;
  assign row_word = disp_all[row_idx];

  // column 0 is the MSB
  generate
    for (gi = 0; gi < BITS; gi++) begin : g_rev
      assign word_rev[gi] = row_word[BITS-1-gi];
    end
  endgenerate

  assign bit_cur = word_rev[col_idx];

  logic s1_active_reg;
  logic s1_in_array_reg;
  logic s1_border_reg;
  logic s1_bit_reg;
  logic [2:0] color_reg;
  logic [2:0] color_next;

  // -------------------------------------------------------------------------
  // Stage 2: colour select
  // -------------------------------------------------------------------------
  always_comb begin
    color_next = 3'b000;
    if (!s1_active_reg)
      color_next = 3'b000;
    else if (!s1_in_array_reg)
      color_next = C_BG;
    else if (s1_border_reg)
      color_next = C_BORDER;
    else if (s1_bit_reg)
      color_next = C_ON;
    else
      color_next = C_OFF;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_active_reg   <= 1'b0;
      s1_in_array_reg <= 1'b0;
      s1_border_reg   <= 1'b0;
      s1_bit_reg      <= 1'b0;
      color_reg       <= 3'b000;
    end else if (px_en) begin
      s1_active_reg   <= activevideo;
      s1_in_array_reg <= in_array_cur;
      s1_border_reg   <= border_cur;
      s1_bit_reg      <= bit_cur;
      color_reg       <= color_next;
    end
  end

  assign color_px = color_reg;

endmodule

// File: tb/tb_led_bank_display.sv
// ---------------------------------------------------------------------------
// tb_led_bank_display
// Directed, table-driven bench for led_bank_display with default parameters
// (8 LEDs x 4 rows, 80x80 cells, 8-pixel border). Works for both builds:
// expectations that differ with LED_SHADOW_EN are selected by SHADOW.
// ---------------------------------------------------------------------------
module tb_led_bank_display;

`ifdef LED_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  localparam logic [2:0] ON  = 3'b010;
  localparam logic [2:0] OFF = 3'b001;
  localparam logic [2:0] BRD = 3'b111;
  localparam logic [2:0] BG  = 3'b000;
  localparam logic [2:0] BLK = 3'b000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       px_en = 1'b0;
  logic [9:0] x_px = '0;
  logic [9:0] y_px = '0;
  logic       activevideo = 1'b0;
  logic       frame_irq;
  logic [2:0] color_px;

  led_bank_display_if #(.BITS(8)) wr_bus ();

  led_bank_display dut (
    .clk         (clk),
    .rstn        (rstn),
    .px_en       (px_en),
    .x_px        (x_px),
    .y_px        (y_px),
    .activevideo (activevideo),
    .wr          (wr_bus),
    .frame_irq   (frame_irq),
    .color_px    (color_px)
  );

  always #5 clk = ~clk;

  int n_vec   = 0;
  int n_bad   = 0;
  int gap     = 0;
  int irq_cnt = 0;

  // a one-clk pulse is seen at exactly one falling edge
  always @(negedge clk) if (frame_irq === 1'b1) irq_cnt++;

  typedef struct {
    int         x;
    int         y;
    bit         act;
    logic [2:0] want;
  } vec_t;

  vec_t blank_tab[12];
  vec_t lit_tab[11];

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int x, input int y, input bit act);
    x_px        = 10'(x);
    y_px        = 10'(y);
    activevideo = act;
    px_en       = 1'b1;
    tick();
    px_en = 1'b0;
    repeat (gap) tick();
  endtask

  // one x==0 strobe per line from line 0 up to line y
  task automatic walk_lines(input int y, input bit act);
    for (int l = 0; l <= y; l++) strobe(0, l, (l == y) ? act : 1'b0);
  endtask

  // continue line y up to column x, plus one strobe to flush stage 2
  task automatic run_x(input int x, input int y, input bit act);
    for (int i = 1; i <= x; i++) strobe(i, y, act);
    strobe(x + 1, y, act);
  endtask

  task automatic probe(input string name, input int x, input int y, input bit act,
                       input logic [2:0] want);
    walk_lines(y, act);
    run_x(x, y, act);
    check3($sformatf("%s (%0d,%0d)", name, x, y), color_px, want);
  endtask

  task automatic commit_strobe();
    strobe(0, 480, 1'b0);
  endtask

  task automatic write_row(input int r, input logic [7:0] d);
    int t;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_row   = 3'(r);
    wr_bus.wr_data  = d;
    t = 0;
    while (!wr_bus.wr_ready && t < 8) begin
      tick();
      t++;
    end
    if (t == 8) begin
      n_vec++;
      n_bad++;
      $display("FAIL write_timeout row %0d: wr_ready stayed 0, expected 1", r);
    end
    tick();
    wr_bus.wr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int irq_base;

    blank_tab[0]  = '{10, 10, 1'b1, OFF};
    blank_tab[1]  = '{7, 40, 1'b1, BRD};
    blank_tab[2]  = '{8, 40, 1'b1, OFF};
    blank_tab[3]  = '{71, 40, 1'b1, OFF};
    blank_tab[4]  = '{72, 40, 1'b1, BRD};
    blank_tab[5]  = '{40, 7, 1'b1, BRD};
    blank_tab[6]  = '{40, 72, 1'b1, BRD};
    blank_tab[7]  = '{700, 10, 1'b1, BG};
    blank_tab[8]  = '{40, 330, 1'b1, BG};
    blank_tab[9]  = '{40, 100, 1'b0, BLK};
    blank_tab[10] = '{639, 319, 1'b1, BRD};
    blank_tab[11] = '{600, 250, 1'b1, OFF};

    // row0=8'h80, row1=8'hA5, row2=8'hFF, row3=0
    lit_tab[0]  = '{40, 120, 1'b1, ON};
    lit_tab[1]  = '{120, 120, 1'b1, OFF};
    lit_tab[2]  = '{200, 120, 1'b1, ON};
    lit_tab[3]  = '{280, 120, 1'b1, OFF};
    lit_tab[4]  = '{440, 120, 1'b1, ON};
    lit_tab[5]  = '{600, 120, 1'b1, ON};
    lit_tab[6]  = '{40, 40, 1'b1, ON};
    lit_tab[7]  = '{600, 40, 1'b1, OFF};
    lit_tab[8]  = '{360, 200, 1'b1, ON};
    lit_tab[9]  = '{40, 280, 1'b1, OFF};
    lit_tab[10] = '{40, 85, 1'b1, BRD};

    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_row   = '0;
    wr_bus.wr_data  = '0;

    // reset state
    repeat (3) tick();
    check3("reset color_px", color_px, 3'b000);
    check3("reset frame_irq", {2'b00, frame_irq}, 3'b000);
    check3("reset wr_ready", {2'b00, wr_bus.wr_ready}, 3'b001);
    rstn = 1'b1;
    tick();

    // empty display
    for (int i = 0; i < 12; i++)
      probe($sformatf("blank%0d", i), blank_tab[i].x, blank_tab[i].y,
            blank_tab[i].act, blank_tab[i].want);

    // row 1 write is invisible until commit only in the shadowed build
    write_row(1, 8'hA5);
    probe("row1 before commit", 40, 120, 1'b1, SHADOW ? OFF : ON);

    irq_base = irq_cnt;
    write_row(0, 8'h01);
    write_row(0, 8'h80);
    write_row(2, 8'hFF);
    write_row(5, 8'h00);
    commit_strobe();
    repeat (3) tick();
    check_int("irq after dirty commit", irq_cnt - irq_base, SHADOW ? 1 : 0);

    irq_base = irq_cnt;
    commit_strobe();
    repeat (3) tick();
    check_int("irq after clean commit", irq_cnt - irq_base, 0);

    for (int i = 0; i < 11; i++)
      probe($sformatf("lit%0d", i), lit_tab[i].x, lit_tab[i].y,
            lit_tab[i].act, lit_tab[i].want);

    // write held through the commit cycle
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_row   = 3'd3;
    wr_bus.wr_data  = 8'hC3;
    x_px = 10'd0;
    y_px = 10'd480;
    activevideo = 1'b0;
    px_en = 1'b1;
    #1;
    check3("wr_ready in commit cycle", {2'b00, wr_bus.wr_ready}, SHADOW ? 3'b000 : 3'b001);
    tick();
    px_en = 1'b0;
    #1;
    check3("wr_ready after commit", {2'b00, wr_bus.wr_ready}, 3'b001);
    tick();
    wr_bus.wr_valid = 1'b0;
    probe("row3 after held write", 40, 280, 1'b1, SHADOW ? OFF : ON);
    commit_strobe();
    probe("row3 col0 next frame", 40, 280, 1'b1, ON);
    probe("row3 col2 next frame", 200, 280, 1'b1, OFF);
    probe("row3 col7 next frame", 600, 280, 1'b1, ON);

    // reset in the middle of a line
    walk_lines(100, 1'b1);
    run_x(50, 100, 1'b1);
    check3("pre-reset row1 col0", color_px, ON);
    rstn = 1'b0;
    #1;
    check3("color during reset", color_px, 3'b000);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    probe("row1 after reset", 40, 120, 1'b1, OFF);
    probe("row2 after reset", 360, 200, 1'b1, OFF);

    // mid-frame write at line 200
    irq_base = irq_cnt;
    walk_lines(200, 1'b1);
    write_row(2, 8'hFF);
    run_x(360, 200, 1'b1);
    check3("row2 same frame (360,200)", color_px, SHADOW ? OFF : ON);
    commit_strobe();
    repeat (3) tick();
    check_int("irq for line-200 write", irq_cnt - irq_base, SHADOW ? 1 : 0);
    probe("row2 after commit", 360, 210, 1'b1, ON);

    // two-strobe latency with px_en every 4 clk
    gap = 3;
    walk_lines(40, 1'b1);
    for (int i = 1; i <= 8; i++) strobe(i, 40, 1'b1);
    check3("latency after x=8 strobe", color_px, BRD);
    tick();
    check3("hold between strobes", color_px, BRD);
    strobe(9, 40, 1'b1);
    check3("latency after x=9 strobe", color_px, OFF);
    gap = 0;

    if (!SHADOW) check_int("irq total without shadow", irq_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/led_bank_display.md
# led_bank_display

Parametrised LED-array renderer for the VGA pipeline: draws ROWS rows of BITS square "LEDs", each row showing one data word, MSB leftmost. It sits beside the VGA timing generator, consumes its pixel coordinates and pixel strobe, and drives a 3-bit colour into the pixel mux. Row words are written through a valid/ready port. They are double-buffered and committed only at a frame boundary, and a one-cycle interrupt signals the commit.

## Interface
Parameters:
- BITS, 8: LEDs per row (1..16).
- ROWS, 4: number of rows (1..8).
- LED_W, 80: LED cell width in pixels.
- LED_H, 80: LED cell height in pixels.
- BORDER, 8: border thickness in pixels; must be < LED_W/2 and < LED_H/2.
- X0, 0: left edge of the array, in pixels.
- Y0, 0: top edge of the array, in pixels.
- V_ACTIVE, 480: first blanking line; used as the commit line.
- C_ON, 3'b010: colour of a lit LED.
- C_OFF, 3'b001: colour of an unlit LED.
- C_BORDER, 3'b111: border colour.
- C_BG, 3'b000: background colour.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- px_en  in  1  pixel strobe, one clk wide; all pixel-path state advances only on it.
- x_px  in  10  current pixel column.
- y_px  in  10  current pixel line.
- activevideo  in  1  visible region.
- wr_valid  in  1  row-write request.
- wr_ready  out  1  write accepted when high together with wr_valid.
- wr_row  in  3  target row; values >= ROWS are accepted and dropped.
- wr_data  in  BITS  row word.
- frame_irq  out  1  one-clk pulse on commit.
- color_px  out  3  pixel colour.

## Operation
- Storage: two arrays, pend[ROWS] and disp[ROWS], plus a dirty flag. A handshake writes pend[wr_row] and sets dirty. Repeated writes to the same row before a commit: the last one wins.
- Commit: happens on the px_en cycle with x_px==0 and y_px==V_ACTIVE. In that cycle disp is loaded from pend. If dirty was set, frame_irq pulses and dirty clears. A commit with dirty clear does nothing and raises no irq.
- wr_ready is low only during the commit cycle; it is high in every other cycle.
- Geometry uses counters, with no division:
  - Horizontal: on px_en with x_px==X0, the in-cell counter cx=0 and the column index col=0. On each later px_en, cx increments; at LED_W-1 it wraps to 0 and col increments. In-array while col<BITS.
  - Vertical: on px_en with x_px==0, the same scheme applies using y_px==Y0, cy, row, LED_H and ROWS.
- Pipeline stage 1 (on px_en): registers activevideo, the in-array flag, the border flag and the selected bit disp[row][BITS-1-col].
  - Border: cx<BORDER, cx>=LED_W-BORDER, cy<BORDER or cy>=LED_H-BORDER.
- Pipeline stage 2 (on px_en): color_px selection.
  - Inactive: 3'b000.
  - Outside the array: C_BG.
  - On a border: C_BORDER.
  - Otherwise: C_ON if the bit is 1, else C_OFF.
- Width rules: cx is $clog2(LED_W) bits, col is $clog2(BITS+1) bits. col and row saturate at BITS and ROWS (no wrap into the array).

## Timing
- Reset values: color_px=0, frame_irq=0, wr_ready=1, pend/disp=0, dirty=0, all counters 0, pipeline valid=0.
- Latency: color_px corresponds to the coordinates presented 2 px_en strobes earlier. Between strobes, color_px holds its value.
- frame_irq is exactly one clk wide, asserted in the clk after the commit cycle.
- Write and commit in the same cycle: the write is refused (wr_ready=0), so the master must hold the request. A write accepted in the cycle before the commit is included in that commit.
- Reset asserted mid-frame: all state clears immediately. After release, rows display as all-off until the first write plus commit.
- If px_en is low in the commit cycle, no commit happens; the commit needs px_en.

## Configuration
- LED_SHADOW_EN defined: double buffering, frame-synchronous commit and frame_irq, as described above.
- LED_SHADOW_EN undefined:
  - pend is removed and writes go straight to disp, taking effect on the next strobe.
  - wr_ready is tied to 1 and frame_irq is tied to 0.
  - Tearing is allowed.

## Test plan
- Reset, then one full 640x480 frame with no writes -> every LED interior pixel is C_OFF and border pixels are C_BORDER; pixel (700,10) shows C_BG; blanking shows 3'b000.
- Write row 1 = 8'hA5 mid-frame (y=100) -> display is unchanged until y=480; frame_irq pulses once; next frame, pixel (40,120) is C_ON and pixel (120,120) is C_OFF.
- Two writes to row 0 (8'h01, then 8'h80) before a commit -> after the commit only LED 0 (x 0..79) is lit; exactly one irq.
- wr_valid held through the commit cycle -> wr_ready=0 for exactly that cycle; the write is accepted the next cycle and lands in the following frame.
- Border edges with LED_W=80, BORDER=8 -> x=7 is border, x=8 is interior, x=71 is interior, x=72 is border; latency is 2 strobes with px_en every 4 clk.
- Build without LED_SHADOW_EN, write row 2 = 8'hFF at y=200 -> lines from 200 onwards within row 2 show C_ON immediately; frame_irq is never asserted.
